// File: rtl/kmap4_parity_rx_if.sv
// -----------------------------------------------------------------------------
// kmap4_parity_rx_if
// Bundle of the serial-side inputs and the nibble output handshake of the
// kmap4_parity_rx receiver.
//   bit_en     : sample strobe for one serial bit (driven by master)
//   rx_in      : serial line, idles high (driven by master)
//   out_ready  : consumer can accept the held nibble (driven by master)
//   out_valid  : held frame is present (driven by slave)
//   out_data   : received nibble {a,b,c,d} (driven by slave)
//   out_perr   : parity error flag of the held frame (driven by slave)
//   out_ferr   : framing error flag of the held frame (driven by slave)
//   overrun    : sticky, a completed frame was discarded (driven by slave)
// -----------------------------------------------------------------------------
interface kmap4_parity_rx_if;
   logic       bit_en;
   logic       rx_in;
   logic       out_ready;
   logic       out_valid;
   logic [3:0] out_data;
   logic       out_perr;
   logic       out_ferr;
   logic       overrun;

   modport slave (
      input  bit_en,
      input  rx_in,
      input  out_ready,
      output out_valid,
      output out_data,
      output out_perr,
      output out_ferr,
      output overrun
   );

   modport master (
      output bit_en,
      output rx_in,
      output out_ready,
      input  out_valid,
      input  out_data,
      input  out_perr,
      input  out_ferr,
      input  overrun
   );
endinterface

// File: rtl/kmap4_parity_rx.sv
// -----------------------------------------------------------------------------
// kmap4_parity_rx
// Receiver/checker for the parity-protected nibble link. Frame on the line,
// one bit per bit_en strobe: start(0), a, b, c, d, p, stop(1).
// The nibble is recomputed against p (even parity over data+p) and the stop
// bit is optionally checked. Every completed frame, good or bad, is offered on
// a one-entry valid/ready output register.
// Ports:
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : kmap4_parity_rx_if.slave (bit_en, rx_in, out_ready in;
//            out_valid, out_data, out_perr, out_ferr, overrun out)
// Parameter:
//   STOP_CHECK : 1 = report framing errors, 0 = out_ferr tied to 0
// -----------------------------------------------------------------------------
module kmap4_parity_rx #(
   parameter bit STOP_CHECK = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   kmap4_parity_rx_if.slave        bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_PAR  = 2'd2,
      S_STOP = 2'd3
   } state_t;

   // frame state
   state_t     r_state;
   state_t     w_state_next;
   logic [1:0] r_bit_cnt;
   logic [1:0] w_bit_cnt_next;
   logic [3:0] r_shift;
   logic [3:0] w_shift_next;
   logic       r_par;
   logic       w_par_next;
   logic       w_frame_done;

   // frame results
   logic       w_perr;
   logic       w_ferr;

   // output register
   logic       r_out_valid;
   logic [3:0] r_out_data;
   logic       r_out_perr;
   logic       r_out_ferr;
   logic       r_overrun;
   logic       w_xfer;
   logic       w_load;

   // ---------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_bit_cnt <= 2'd0;
         r_shift   <= 4'h0;
         r_par     <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_bit_cnt <= w_bit_cnt_next;
         r_shift   <= w_shift_next;
         r_par     <= w_par_next;
      end
   end

   // ---------------------------------------------------------------
   // FSM next-state. Nothing moves without bit_en, so gaps between
   // strobes simply hold the frame where it is.
   // ---------------------------------------------------------------
   always_comb begin
      w_state_next   = r_state;
      w_bit_cnt_next = r_bit_cnt;
      w_shift_next   = r_shift;
      w_par_next     = r_par;
      w_frame_done   = 1'b0;
      if (bus.bit_en) begin
         case (r_state)
            S_IDLE: begin
               // a high sample is line idle; the first low sample is a start bit
               if (!bus.rx_in) begin
                  w_state_next   = S_DATA;
                  w_bit_cnt_next = 2'd0;
               end
            end
            S_DATA: begin
               // MSB first: 'a' ends up in bit 3
               w_shift_next   = {r_shift[2:0], bus.rx_in};
               w_bit_cnt_next = r_bit_cnt + 2'd1;
               if (r_bit_cnt == 2'd3) begin
                  w_state_next = S_PAR;
               end
            end
            S_PAR: begin
               w_par_next   = bus.rx_in;
               w_state_next = S_STOP;
            end
            S_STOP: begin
               // stop bit is sampled combinationally in the completing cycle
               w_frame_done = 1'b1;
               w_state_next = S_IDLE;
            end
            default: begin
               w_state_next = S_IDLE;
            end
         endcase
      end
   end

   // even parity across data plus received p; any odd count is an error
   assign w_perr = ^{r_shift, r_par};
   assign w_ferr = STOP_CHECK & ~bus.rx_in;

   // A transfer frees the slot in the same cycle, so a completing frame can
   // replace the departing one with no bubble.
   assign w_xfer = r_out_valid & bus.out_ready;
   assign w_load = w_frame_done & (~r_out_valid | w_xfer);

   // ---------------------------------------------------------------
   // Output register and sticky overrun
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= 4'h0;
         r_out_perr  <= 1'b0;
         r_out_ferr  <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_shift;
            r_out_perr  <= w_perr;
            r_out_ferr  <= w_ferr;
         end else if (w_xfer) begin
            r_out_valid <= 1'b0;
         end
         // slot full and not draining: new frame is dropped, held one kept
         if (w_frame_done && !w_load) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_perr  = r_out_perr;
   assign bus.out_ferr  = r_out_ferr;
   assign bus.overrun   = r_overrun;

endmodule
